// File: rtl/fb_pkg.sv
// Shared frame buffer definitions: geometry, drawing modes, engine states and
// the {y,x} address packing used by both the drawing engine and the VGA reader.
package fb_pkg;

  localparam int FB_W   = 256;
  localparam int FB_H   = 128;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    MODE_FILL    = 2'b00,
    MODE_CHECKER = 2'b01,
    MODE_INVERT  = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic [ADDR_W-1:0] fb_addr_pack(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
    return {y, x};
  endfunction

  // Row coordinate has only 7 bits, so grid bit 7 of y reads as zero.
  function automatic logic checker_bit(input logic [X_W-1:0] x,
                                       input logic [Y_W-1:0] y,
                                       input logic [2:0]     g,
                                       input logic           color);
    logic [X_W-1:0] y_ext;
    y_ext = {1'b0, y};
    return x[g] ^ y_ext[g] ^ color;
  endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Rectangle command channel. Transfer happens on the rising clock edge where
// cmd_valid && cmd_ready; the source holds all fields stable until then.
interface fb_rect_writer_if;
  import fb_pkg::*;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [X_W-1:0] cmd_x0;
  logic [X_W-1:0] cmd_x1;
  logic [Y_W-1:0] cmd_y0;
  logic [Y_W-1:0] cmd_y1;
  logic [1:0]     cmd_mode;
  logic           cmd_color;
  logic [2:0]     cmd_grid;

  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_mode, cmd_color, cmd_grid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_mode, cmd_color, cmd_grid,
    output cmd_ready
  );

endinterface

// File: rtl/fb_raster_counter.sv
// Raster walker over an inclusive rectangle, x inner and y outer. Holds at the
// last pixel so a stray step can never leave the rectangle.
module fb_raster_counter
  import fb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic [X_W-1:0] i_xmin,
  input  logic [X_W-1:0] i_xmax,
  input  logic [Y_W-1:0] i_ymin,
  input  logic [Y_W-1:0] i_ymax,
  input  logic           i_step,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [X_W-1:0] r_xmin;
  logic [X_W-1:0] r_xmax;
  logic [Y_W-1:0] r_ymax;
  logic           w_x_end;

  assign w_x_end = (r_x == r_xmax);
  assign o_last  = w_x_end && (r_y == r_ymax);
  assign o_x     = r_x;
  assign o_y     = r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymax <= '0;
    end else if (i_load) begin
      r_x    <= i_xmin;
      r_y    <= i_ymin;
      r_xmin <= i_xmin;
      r_xmax <= i_xmax;
      r_ymax <= i_ymax;
    end else if (i_step && !o_last) begin
      // Bounds compared before incrementing: 255/127 never wrap.
      if (w_x_end) begin
        r_x <= r_xmin;
        r_y <= r_y + 7'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle drawing engine on frame buffer port A: FILL, CHECKER and INVERT
// (read then write) over an inclusive rectangle, one-cycle done pulse at the end.
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fb_rect_writer_if.slave   cmd,
  input  logic              abort,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_din,
  output logic              fb_we,
  input  logic              fb_dout,
  output logic              busy,
  output logic              done,
  output state_e            dbg_state
);

  state_e         r_state;
  state_e         w_next;
  mode_e          r_mode;
  logic           r_color;
  logic [2:0]     r_grid;

  logic           w_accept;
  logic           w_step;
  logic [X_W-1:0] w_xmin;
  logic [X_W-1:0] w_xmax;
  logic [Y_W-1:0] w_ymin;
  logic [Y_W-1:0] w_ymax;
  logic [X_W-1:0] w_x;
  logic [Y_W-1:0] w_y;
  logic           w_last;

  assign w_accept = cmd.cmd_valid && (r_state == ST_IDLE);
  assign w_xmin   = (cmd.cmd_x0 > cmd.cmd_x1) ? cmd.cmd_x1 : cmd.cmd_x0;
  assign w_xmax   = (cmd.cmd_x0 > cmd.cmd_x1) ? cmd.cmd_x0 : cmd.cmd_x1;
  assign w_ymin   = (cmd.cmd_y0 > cmd.cmd_y1) ? cmd.cmd_y1 : cmd.cmd_y0;
  assign w_ymax   = (cmd.cmd_y0 > cmd.cmd_y1) ? cmd.cmd_y0 : cmd.cmd_y1;

  fb_raster_counter u_raster (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_xmin (w_xmin),
    .i_xmax (w_xmax),
    .i_ymin (w_ymin),
    .i_ymax (w_ymax),
    .i_step (w_step),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_FILL;
      r_color <= 1'b0;
      r_grid  <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode  <= mode_e'(cmd.cmd_mode);
        r_color <= cmd.cmd_color;
        r_grid  <= cmd.cmd_grid;
      end
    end
  end

  // Abort drops straight to IDLE; the write presented this cycle still lands.
  always_comb begin
    w_next = r_state;
    w_step = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (mode_e'(cmd.cmd_mode) == MODE_INVERT) ? ST_RD : ST_FILL;
        end
      end
      ST_FILL: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else begin
          w_step = 1'b1;
          w_next = w_last ? ST_DONE : ST_FILL;
        end
      end
      ST_RD: begin
        w_next = abort ? ST_IDLE : ST_WR;
      end
      ST_WR: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else begin
          w_step = 1'b1;
          w_next = w_last ? ST_DONE : ST_RD;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Port A drive depends only on registered state/counters (plus read data in WR).
  always_comb begin
    fb_addr = '0;
    fb_din  = 1'b0;
    fb_we   = 1'b0;
    case (r_state)
      ST_FILL: begin
        fb_we   = 1'b1;
        fb_addr = fb_addr_pack(w_x, w_y);
        fb_din  = (r_mode == MODE_CHECKER) ? checker_bit(w_x, w_y, r_grid, r_color)
                                           : r_color;
      end
      ST_RD: begin
        fb_addr = fb_addr_pack(w_x, w_y);
      end
      ST_WR: begin
        fb_we   = 1'b1;
        fb_addr = fb_addr_pack(w_x, w_y);
        fb_din  = ~fb_dout;
      end
      default: begin
        fb_addr = '0;
      end
    endcase
  end

  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign dbg_state     = r_state;

endmodule
